// File: rtl/ext_int_ctrl.sv
// ext_int_ctrl: external-interrupt and rfi sequencer owning SRR0/SRR1.
// Takes interrupts only at commit; strobes decode from state alone.
module ext_int_ctrl #(
   parameter int          MSR_WIDTH   = 32,
   parameter logic [31:0] VEC_EXT     = 32'h00000500,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ext_irq,
   input  logic                 msr_ee,
   input  logic [MSR_WIDTH-1:0] msr_rd,
   input  logic                 commit,
   input  logic [31:0]          commit_npc,
   input  logic                 rfi,
   input  logic                 srr_wr,
   input  logic                 srr_sel,
   input  logic [31:0]          srr_wd,
   output logic [31:0]          srr0,
   output logic [MSR_WIDTH-1:0] srr1,
   output logic                 msr_wr,
   output logic [MSR_WIDTH-1:0] msr_wd,
   output logic                 flush,
   output logic                 redirect,
   output logic [31:0]          redirect_pc,
   output logic                 irq_ack
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] TAKE = 2'd1;
   localparam logic [1:0] RFI  = 2'd2;
   logic [1:0]             r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [31:0]            r_srr0;
   logic [MSR_WIDTH-1:0]   r_srr1;
   logic                   w_irq_s;
   logic                   w_take;
   logic                   w_rfi;
   logic [MSR_WIDTH-1:0]   w_clr_ee;
   assign w_irq_s = r_sync[SYNC_STAGES-1];
   assign w_take  = r_state == TAKE;
   assign w_rfi   = r_state == RFI;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_sync  <= '0;
         r_srr0  <= '0;
         r_srr1  <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], ext_irq};
         if (r_state != IDLE)
            r_state <= IDLE;
         else if (commit && rfi)
            r_state <= RFI;
         else if (commit && w_irq_s && msr_ee) begin
            r_srr0  <= commit_npc;
            r_srr1  <= msr_rd;
            r_state <= TAKE;
         end else if (srr_wr) begin
            if (srr_sel)
               r_srr1 <= srr_wd;
            else
               r_srr0 <= srr_wd;
         end
      end
   end
   // EE is bit 16 in big-endian numbering
   always_comb begin
      w_clr_ee                = r_srr1;
      w_clr_ee[MSR_WIDTH-17]  = 1'b0;
   end
   assign srr0        = r_srr0;
   assign srr1        = r_srr1;
   assign flush       = w_take | w_rfi;
   assign redirect    = w_take | w_rfi;
   assign msr_wr      = w_take | w_rfi;
   assign irq_ack     = w_take;
   assign redirect_pc = w_take ? VEC_EXT : w_rfi ? r_srr0 : 32'h0;
   assign msr_wd      = w_take ? w_clr_ee : w_rfi ? r_srr1 : '0;
endmodule
